// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder producing sum, carry-out and signed overflow after WIDTH cycles
// Ports: clk/rst (sync, active-high); start, a, b, cin captured in IDLE;
//        busy high during SHIFT; done pulses one cycle with registered sum, cout, ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = WIDTH - 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] ra, rb;
    // holds the lower WIDTH-1 result bits; the MSB is the final slice's sum bit
    logic [RW-1:0] rs;
    logic [CW-1:0] cnt;
    logic c, s, c_next, last;
    assign s = ra[0] ^ rb[0] ^ c;
    assign c_next = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;
    always_comb begin
        next = state;
        busy = state == SHIFT;
        done = state == DONE;
        if (state == IDLE && start) next = SHIFT;
        if (state == SHIFT && last) next = DONE;
        if (state == DONE) next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == IDLE && start) begin
            ra  <= a;
            rb  <= b;
            c   <= cin;
            cnt <= '0;
        end else if (state == SHIFT) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            c   <= c_next;
            rs  <= RW'({s, rs} >> 1);
            cnt <= cnt + CW'(1);
            // on the last slice c is the carry into the MSB
            if (last) begin
                sum  <= {s, rs};
                cout <= c_next;
                ovf  <= c ^ c_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder against an arithmetic reference model
module tb_serial_adder;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout, ovf;
    logic [W-1:0] sum;
    int checks = 0, errors = 0;
    bit chk_en = 1'b0;
    int m_t = -1;
    logic [W-1:0] m_sum = '0, p_sum = '0;
    logic m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: m_t counts cycles since the accepted start (-1 when idle);
    // the result is computed with plain integer arithmetic at acceptance.
    always @(posedge clk) begin
        logic [W:0] full;
        if (rst) begin
            m_t = -1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_t < 0) begin
            if (start) begin
                full = a + b + cin;
                p_sum = full[W-1:0];
                p_cout = full[W];
                p_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
                m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == W) begin
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
            if (m_t == W + 1) m_t = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_t >= 0 && m_t < W);
            chk("done", done, m_t == W);
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
            chk("ovf", ovf, m_ovf);
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
        int lat, bc;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        lat = 0; bc = 0;
        while (!done && lat < 20) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, W);
        chk({nm, " busy cycles"}, bc, W);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, cout, ec);
        chk({nm, " ovf"}, ovf, eo);
        chk({nm, " model sum"}, m_sum, es);
        chk({nm, " model ovf"}, m_ovf, eo);
        @(negedge clk);
    endtask

    initial begin
        int nd, last_d, prev;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pos ovf");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "neg ovf");
        run_op(8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0, "neg cin");
        run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "plain cin");
        // start pulses during SHIFT and DONE must be ignored
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            start = (i == 2 || i == 5 || i == W);
            a = '0; b = '0; cin = 1'b0;
            nd += int'(done);
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore start done count", nd, 1);
        chk("ignore start sum", sum, 8'h00);
        chk("ignore start cout", cout, 1);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pre reset");
        // reset in the middle of SHIFT
        a = 8'h3C; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
        chk("abort ovf", ovf, 0);
        nd = 0;
        repeat (12) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("abort no done", nd, 0);
        run_op(8'h3C, 8'h11, 1'b0, 8'h4D, 1'b0, 1'b0, "after abort");
        // start held high: back-to-back results
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        nd = 0; last_d = 0; prev = -1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done) begin
                if (last_d != 0) chk("b2b done width", 2, 1);
                if (prev >= 0) chk("b2b spacing", i - prev, W + 2);
                chk("b2b sum", sum, 8'h02);
                prev = i;
                nd++;
            end
            last_d = int'(done);
        end
        start = 1'b0;
        chk("b2b done count", nd >= 3, 1);
        repeat (12) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
